// File: rtl/ula_issue.sv
// ula_issue: registered RV32I ALU-op decode feeding a two-entry skid buffer.
// Each accepted instruction is decoded into an ALU op code plus two operands
// and queued in order: main drives the outputs, skid absorbs one extra entry
// when the ALU stage stalls.  in_ready comes straight from a flop, so
// out_ready never reaches it combinationally.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_EMPTY  | no entry held, out_valid low
// ST_MAIN   | main holds the entry on the outputs, skid empty
// ST_BOTH   | main and skid both hold entries, in_ready low
module ula_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data1_in,
    output logic [31:0] data2_in,
    output logic [3:0]  select_ula,
    output logic        illegal,
    input  logic        flush
);

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_BOTH  = 2'd2
    } occ_t;

    occ_t state;
    occ_t state_nxt;

    // Decoded view of the instruction currently offered upstream
    logic [3:0]  dec_sel;
    logic [31:0] dec_d1;
    logic [31:0] dec_d2;
    logic        dec_ill;

    // Held entries
    logic [3:0]  main_sel;
    logic [31:0] main_d1;
    logic [31:0] main_d2;
    logic        main_ill;
    logic [3:0]  skid_sel;
    logic [31:0] skid_d1;
    logic [31:0] skid_d2;
    logic        skid_ill;

    // Datapath steering chosen by the occupancy FSM
    logic accept;
    logic take;
    logic load_main_dec;
    logic load_main_skid;
    logic load_skid_dec;
    logic clear_main;
    logic ready_nxt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        unused_rd;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_u     = {instr[31:12], 12'b0};
    assign shamt     = {27'b0, instr[24:20]};
    assign unused_rd = ^instr[11:7];

    // Shared funct3 -> op table for register and immediate forms
    function automatic logic [3:0] f3_to_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // Instruction decode; anything undecodable becomes a zeroed illegal entry
    always_comb begin
        dec_sel = OP_NONE;
        dec_d1  = 32'b0;
        dec_d2  = 32'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_d1 = rs1_val;
                dec_d2 = rs2_val;
                if (funct7 == F7_BASE) begin
                    dec_sel = f3_to_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_sel = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_sel = OP_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_d1 = rs1_val;
                dec_d2 = imm_i;
                if (funct3 == 3'b001) begin
                    dec_d2  = shamt;
                    dec_sel = OP_SLL;
                    dec_ill = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_d2 = shamt;
                    if (funct7 == F7_BASE) begin
                        dec_sel = OP_SRL;
                    end else if (funct7 == F7_ALT) begin
                        dec_sel = OP_SRA;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end else begin
                    dec_sel = f3_to_op(funct3);
                end
            end
            OPC_LUI: begin
                dec_sel = OP_ADD;
                dec_d2  = imm_u;
            end
            OPC_AUIPC: begin
                dec_sel = OP_ADD;
                dec_d1  = pc;
                dec_d2  = imm_u;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        if (dec_ill) begin
            dec_sel = OP_NONE;
            dec_d1  = 32'b0;
            dec_d2  = 32'b0;
        end
    end

    assign out_valid  = (state != ST_EMPTY);
    assign select_ula = main_sel;
    assign data1_in   = main_d1;
    assign data2_in   = main_d2;
    assign illegal    = main_ill;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // Occupancy next-state and datapath steering; flush overrides everything
    always_comb begin
        state_nxt      = state;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid_dec  = 1'b0;
        clear_main     = 1'b0;
        if (flush) begin
            state_nxt  = ST_EMPTY;
            clear_main = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_dec = 1'b1;
                        state_nxt     = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (accept && take) begin
                        load_main_dec = 1'b1;
                    end else if (take) begin
                        clear_main = 1'b1;
                        state_nxt  = ST_EMPTY;
                    end else if (accept) begin
                        load_skid_dec = 1'b1;
                        state_nxt     = ST_BOTH;
                    end
                end
                ST_BOTH: begin
                    if (take) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_MAIN;
                    end
                end
                default: begin
                    state_nxt  = ST_EMPTY;
                    clear_main = 1'b1;
                end
            endcase
        end
        ready_nxt = (state_nxt != ST_BOTH);
    end

    // Occupancy state and registered in_ready (held low through reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= ready_nxt;
        end
    end

    // Main entry: loaded from decode or promoted from skid, zeroed when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_sel <= OP_NONE;
            main_d1  <= 32'b0;
            main_d2  <= 32'b0;
            main_ill <= 1'b0;
        end else if (clear_main) begin
            main_sel <= OP_NONE;
            main_d1  <= 32'b0;
            main_d2  <= 32'b0;
            main_ill <= 1'b0;
        end else if (load_main_skid) begin
            main_sel <= skid_sel;
            main_d1  <= skid_d1;
            main_d2  <= skid_d2;
            main_ill <= skid_ill;
        end else if (load_main_dec) begin
            main_sel <= dec_sel;
            main_d1  <= dec_d1;
            main_d2  <= dec_d2;
            main_ill <= dec_ill;
        end
    end

    // Skid entry: captures a new decode while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_sel <= OP_NONE;
            skid_d1  <= 32'b0;
            skid_d2  <= 32'b0;
            skid_ill <= 1'b0;
        end else if (load_skid_dec) begin
            skid_sel <= dec_sel;
            skid_d1  <= dec_d1;
            skid_d2  <= dec_d2;
            skid_ill <= dec_ill;
        end
    end

endmodule

// File: tb/tb_ula_issue.sv
// Bench for ula_issue: directed scenarios plus random traffic, all checked
// against an in-order queue of expected decodes computed from the ISA rules.
module tb_ula_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'b0;
    logic [31:0] rs1_val = 32'b0;
    logic [31:0] rs2_val = 32'b0;
    logic [31:0] pc = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data1_in;
    logic [31:0] data2_in;
    logic [3:0]  select_ula;
    logic        illegal;
    logic        flush = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        ill;
        logic [3:0]  sel;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t q[$];
    bit   rdy_en = 1'b0;

    ula_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .pc         (pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data1_in   (data1_in),
        .data2_in   (data2_in),
        .select_ula (select_ula),
        .illegal    (illegal),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected ALU view of one instruction, from the ISA field rules
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] p);
        exp_t       e;
        logic [3:0] base [8];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         alt;
        bit         shift;
        bit         legal;
        base  = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd6, 4'd9, 4'd10};
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        alt   = (f7 == 7'h20);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        legal = 1'b1;
        e     = '0;
        if (opc == 7'h33) begin
            legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
            e.sel = base[f3] + {3'b0, alt};
            e.d1  = a;
            e.d2  = b;
        end else if (opc == 7'h13) begin
            legal = !shift || (f7 == 7'h00) || (alt && f3 == 3'd5);
            e.sel = base[f3] + {3'b0, (shift && alt)};
            e.d1  = a;
            e.d2  = shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.sel = 4'd1;
            e.d1  = (opc == 7'h17) ? p : 32'b0;
            e.d2  = ins & 32'hFFFF_F000;
        end else begin
            legal = 1'b0;
        end
        if (!legal) e = '{ill: 1'b1, sel: 4'd0, d1: 32'd0, d2: 32'd0};
        return e;
    endfunction

    // Compare DUT against the model queue, then advance the model across the next edge
    task automatic cycle();
        bit   exp_rdy;
        bit   take;
        bit   acc;
        @(negedge clk);
        exp_rdy = rdy_en && (q.size() < 2);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            check("select", {28'b0, select_ula}, {28'b0, q[0].sel});
            check("data1", data1_in, q[0].d1);
            check("data2", data2_in, q[0].d2);
            check("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
        end
        if (rst) begin
            q.delete();
            rdy_en = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                take = (q.size() > 0) && out_ready;
                acc  = in_valid && exp_rdy;
                if (take) void'(q.pop_front());
                if (acc) q.push_back(ref_model(instr, rs1_val, rs2_val, pc));
            end
            rdy_en = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = ins;
        rs1_val  = a;
        rs2_val  = b;
        pc       = p;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    opc = 7'h33;
            2, 3:    opc = 7'h13;
            4:       opc = ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, r[17:0], opc};
    endfunction

    initial begin
        // Reset values
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_select", {28'b0, select_ula}, 32'd0);
        check("rst_data1", data1_in, 32'd0);
        check("rst_data2", data2_in, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // ADD stream
        out_ready = 1'b1;
        offer(32'h002081B3, 32'h55555555, 32'hAAAAAAAA, 32'h0);
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_select", {28'b0, select_ula}, 32'd1);
        check("add_data1", data1_in, 32'h55555555);
        check("add_data2", data2_in, 32'hAAAAAAAA);
        check("add_illegal", {31'b0, illegal}, 32'd0);
        cycle();

        // SRAI and malformed SLLI
        offer(32'h40415093, 32'h83800155, 32'h12345678, 32'h0);
        check("srai_select", {28'b0, select_ula}, 32'd7);
        check("srai_data1", data1_in, 32'h83800155);
        check("srai_data2", data2_in, 32'h00000004);
        offer(32'h40011093, 32'h11111111, 32'h22222222, 32'h0);
        check("slli_bad_illegal", {31'b0, illegal}, 32'd1);
        check("slli_bad_select", {28'b0, select_ula}, 32'd0);
        cycle();

        // LUI / AUIPC
        offer(32'h123452B7, 32'hDEADBEEF, 32'h0, 32'h00001000);
        check("lui_select", {28'b0, select_ula}, 32'd1);
        check("lui_data1", data1_in, 32'd0);
        check("lui_data2", data2_in, 32'h12345000);
        offer(32'h12345297, 32'hDEADBEEF, 32'h0, 32'h00001000);
        check("auipc_data1", data1_in, 32'h00001000);
        check("auipc_data2", data2_in, 32'h12345000);
        cycle();

        // Backpressure: SUB then ADD while stalled
        out_ready = 1'b0;
        offer(32'h40208133, 32'd10, 32'd3, 32'h0);
        offer(32'h002081B3, 32'd7, 32'd8, 32'h0);
        check("bp_ready_low", {31'b0, in_ready}, 32'd0);
        check("bp_hold_sub", {28'b0, select_ula}, 32'd2);
        cycle();
        cycle();
        check("bp_still_sub", {28'b0, select_ula}, 32'd2);
        check("bp_sub_data1", data1_in, 32'd10);
        out_ready = 1'b1;
        cycle();
        check("bp_then_add", {28'b0, select_ula}, 32'd1);
        check("bp_ready_back", {31'b0, in_ready}, 32'd1);
        cycle();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Unknown opcode, then flush with both entries full
        offer(32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4);
        check("bad_opc_illegal", {31'b0, illegal}, 32'd1);
        check("bad_opc_select", {28'b0, select_ula}, 32'd0);
        check("bad_opc_data1", data1_in, 32'd0);
        check("bad_opc_data2", data2_in, 32'd0);
        out_ready = 1'b0;
        offer(32'h002081B3, 32'd1, 32'd2, 32'h0);
        offer(32'h40208133, 32'd3, 32'd4, 32'h0);
        flush    = 1'b1;
        in_valid = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd1);

        // Async reset between edges with both entries full
        offer(32'h002081B3, 32'd5, 32'd6, 32'h0);
        offer(32'h40208133, 32'd7, 32'd8, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_ready", {31'b0, in_ready}, 32'd0);
        q.delete();
        rdy_en = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        check("arst_ready_back", {31'b0, in_ready}, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            instr     = rand_instr();
            rs1_val   = $urandom;
            rs2_val   = $urandom;
            pc        = $urandom;
            cycle();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        check("final_empty", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
